// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and controller state encoding.
package sha256_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [0:7][31:0]  hash_t;   // element 0 (a / H0) is the most significant word
  typedef logic [0:15][31:0] wwin_t;   // element 0 (W0) is the most significant word

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t big_s0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_s1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round: working variables a..h, schedule word and constant in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  hash_t vars_i,
  input  word_t w_i,
  input  word_t k_i,
  output hash_t vars_o
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = vars_i[7] + big_s1(vars_i[4]) + ch(vars_i[4], vars_i[5], vars_i[6]) + k_i + w_i;
    t2 = big_s0(vars_i[0]) + maj(vars_i[0], vars_i[1], vars_i[2]);
    vars_o = {t1 + t2, vars_i[0], vars_i[1], vars_i[2],
              vars_i[3] + t1, vars_i[4], vars_i[5], vars_i[6]};
  end

endmodule

// File: rtl/sha256_core_ctrl.sv
// SHA-256 block sequencer: one round per cycle, hash chaining across blocks, digest handshake.
// Optional SHA256_MIDSTATE_EN adds mid_en/midstate to start a message from a saved hash state.
module sha256_core_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = 64,
  parameter bit          DIGEST_HOLD = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  input  logic         abort,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] digest,
`ifdef SHA256_MIDSTATE_EN
  input  logic         mid_en,
  input  logic [255:0] midstate,
`endif
  output logic         busy
);

  localparam logic [5:0] RND_LAST = 6'(NUM_ROUNDS - 1);

  state_e     state_q, state_d;
  logic       blk_ready_q, blk_ready_d;
  logic       dig_valid_q, dig_valid_d;
  logic       last_q, last_d;
  logic [5:0] rnd_q, rnd_d;
  hash_t      h_q, h_d;
  hash_t      digest_q, digest_d;
  hash_t      vars_q, vars_d;
  wwin_t      w_q, w_d;

  hash_t      vars_rnd;
  hash_t      init_h;
  word_t      w_next;
  logic       accept;

`ifdef SHA256_MIDSTATE_EN
  assign init_h = mid_en ? hash_t'(midstate) : IV;
`else
  assign init_h = IV;
`endif

  // abort wins over a simultaneous offer, so the block is simply not taken.
  assign accept = (state_q == IDLE) && blk_ready_q && blk_valid && !abort;
  assign w_next = small_s1(w_q[14]) + w_q[9] + small_s0(w_q[1]) + w_q[0];

  sha256_round u_round (
    .vars_i (vars_q),
    .w_i    (w_q[0]),
    .k_i    (K[rnd_q]),
    .vars_o (vars_rnd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of process order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: assign defaults first so no path through the case leaves a signal unassigned (latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)             state_d = ROUND;
      ROUND:   if (rnd_q == RND_LAST)  state_d = FINAL;
      FINAL:   state_d = last_q ? OUT : IDLE;
      OUT:     if (!DIGEST_HOLD || dig_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Handshake outputs are registered copies of where the FSM is heading.
  always_comb begin
    blk_ready_d = (state_d == IDLE);
    dig_valid_d = (state_d == OUT);
  end

  always_comb begin
    w_d      = w_q;
    vars_d   = vars_q;
    h_d      = h_q;
    digest_d = digest_q;
    rnd_d    = rnd_q;
    last_d   = last_q;
    if (abort) begin
      h_d = IV;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            w_d    = blk_data;
            vars_d = blk_first ? init_h : h_q;
            h_d    = blk_first ? init_h : h_q;
            rnd_d  = '0;
            last_d = blk_last;
          end
        end
        ROUND: begin
          vars_d = vars_rnd;
          w_d    = {w_q[1:15], w_next};
          rnd_d  = rnd_q + 6'd1;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + vars_q[i];
          if (last_q) digest_d = h_d;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_ready_q <= 1'b0;
      dig_valid_q <= 1'b0;
      last_q      <= 1'b0;
      rnd_q       <= '0;
      h_q         <= IV;
      digest_q    <= '0;
    end else begin
      blk_ready_q <= blk_ready_d;
      dig_valid_q <= dig_valid_d;
      last_q      <= last_d;
      rnd_q       <= rnd_d;
      h_q         <= h_d;
      digest_q    <= digest_d;
    end
  end

  // NOTE: schedule window and working variables need no reset; accept always loads them before use.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    vars_q <= vars_d;
  end

  assign blk_ready = blk_ready_q;
  assign dig_valid = dig_valid_q;
  assign digest    = digest_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// Scoreboard bench for sha256_core_ctrl: FIPS vectors, latency, backpressure, abort and reset.
module tb_sha256_core_ctrl;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_TWO   =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk;
  logic         reset_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         abort;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] digest;
  logic         busy;
`ifdef SHA256_MIDSTATE_EN
  logic         mid_en;
  logic [255:0] midstate;
`endif

  int           n_total = 0;
  int           n_bad   = 0;
  logic [255:0] sb_q[$];

  sha256_core_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .abort     (abort),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .digest    (digest),
`ifdef SHA256_MIDSTATE_EN
    .mid_en    (mid_en),
    .midstate  (midstate),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of cycle 1 (first round cycle).
  task automatic send_block(input logic [511:0] data, input bit first, input bit last,
                            input bit expect_out, input logic [255:0] exp_dig);
    int n = 0;
    blk_data  = data;
    blk_first = first;
    blk_last  = last;
    blk_valid = 1'b1;
    if (expect_out) sb_q.push_back(exp_dig);
    while (!blk_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) check("accept_timeout", 256'(blk_ready), 256'(1));
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // From cycle 1 to cycle 66 after accept, checking the latency points.
  task automatic track(input bit last);
    for (int c = 1; c <= 66; c++) begin
      if (c == 1) check("busy_c1", 256'(busy), 256'(1));
      if (c == 65) begin
        check("dig_valid_c65", 256'(dig_valid), 256'(0));
        check("blk_ready_c65", 256'(blk_ready), 256'(0));
      end
      if (c == 66) begin
        check("dig_valid_c66", 256'(dig_valid), 256'(last));
        check("blk_ready_c66", 256'(blk_ready), 256'(!last));
      end
      if (c < 66) @(negedge clk);
    end
  endtask

  // Scoreboard: each digest handshake pops the oldest expected digest.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && dig_valid && dig_ready) begin
        check("sb_nonempty", 256'(sb_q.size() != 0), 256'(1));
        if (sb_q.size() != 0) check("digest", digest, sb_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    abort     = 1'b0;
    dig_ready = 1'b1;
`ifdef SHA256_MIDSTATE_EN
    mid_en    = 1'b0;
    midstate  = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_blk_ready", 256'(blk_ready), 256'(0));
    check("rst_dig_valid", 256'(dig_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_digest", digest, 256'(0));
    reset_n = 1'b1;
    #1 check("rel_blk_ready_pre", 256'(blk_ready), 256'(0));
    @(negedge clk);
    check("rel_blk_ready_post", 256'(blk_ready), 256'(1));

    // Single-block "abc" and empty message.
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    track(1'b1);
    @(negedge clk);
    send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b1, DIG_EMPTY);
    track(1'b1);
    @(negedge clk);

    // Two-block message, second block offered the cycle blk_ready returns.
    send_block(BLK_TWO1, 1'b1, 1'b0, 1'b0, '0);
    track(1'b0);
    send_block(BLK_TWO2, 1'b0, 1'b1, 1'b1, DIG_TWO);
    track(1'b1);
    @(negedge clk);

    // Backpressure: digest held for 10 cycles with dig_ready low.
    dig_ready = 1'b0;
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    track(1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_digest", digest, DIG_ABC);
      check("bp_dig_valid", 256'(dig_valid), 256'(1));
      check("bp_blk_ready", 256'(blk_ready), 256'(0));
    end
    dig_ready = 1'b1;
    @(negedge clk);
    check("hs_dig_valid", 256'(dig_valid), 256'(0));
    check("hs_blk_ready", 256'(blk_ready), 256'(1));
    check("hs_digest_kept", digest, DIG_ABC);

    // Abort at round 30, then a rejected offer under abort, then chain from IV.
    send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b0, '0);
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_blk_ready", 256'(blk_ready), 256'(1));
    check("abort_dig_valid", 256'(dig_valid), 256'(0));
    blk_data  = BLK_EMPTY;
    blk_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    abort     = 1'b0;
    check("abort_offer_busy", 256'(busy), 256'(0));
    send_block(BLK_ABC, 1'b0, 1'b1, 1'b1, DIG_ABC);
    track(1'b1);
    @(negedge clk);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b1, DIG_ABC);
    track(1'b1);
    @(negedge clk);

    // Asynchronous reset at round 10, then chain from the reset IV.
    send_block(BLK_EMPTY, 1'b1, 1'b1, 1'b0, '0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_blk_ready", 256'(blk_ready), 256'(0));
    check("arst_dig_valid", 256'(dig_valid), 256'(0));
    check("arst_busy", 256'(busy), 256'(0));
    check("arst_digest", digest, 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_rel_blk_ready", 256'(blk_ready), 256'(1));
    send_block(BLK_ABC, 1'b0, 1'b1, 1'b1, DIG_ABC);
    track(1'b1);
    @(negedge clk);

`ifdef SHA256_MIDSTATE_EN
    // Resume the two-block message from the hash state after its first block.
    midstate = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    mid_en   = 1'b1;
    send_block(BLK_TWO2, 1'b1, 1'b1, 1'b1, DIG_TWO);
    mid_en   = 1'b0;
    track(1'b1);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 256'(sb_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
